// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the serial pattern detector.
// Accepts WIDTH-bit words over valid/ready and emits them MSB first, one bit
// per clock, with back-to-back frames at zero gap.
// Optional feature macro: SERIALIZER_PARITY_EN appends one even-parity bit
// after the LSB of every frame.
module bit_serializer #(
   parameter int unsigned WIDTH    = 8,
   parameter logic        IDLE_BIT = 1'b0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             serial_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             busy,
   output logic [7:0]       word_count
);

`ifdef SERIALIZER_PARITY_EN
   localparam int unsigned FRAME = WIDTH + 1;
`else
   localparam int unsigned FRAME = WIDTH;
`endif
   localparam int unsigned CW = $clog2(FRAME + 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           state, nxt_state;
   logic [FRAME-1:0] shreg, nxt_shreg;
   logic [CW-1:0]    cnt, nxt_cnt;
   logic [7:0]       nxt_word_count;
   logic [FRAME-1:0] load_word;
   logic             accept;

   // Frame image loaded on a handshake; the parity bit rides in the LSB slot.
`ifdef SERIALIZER_PARITY_EN
   assign load_word = {data_in, ^data_in};
`else
   assign load_word = data_in;
`endif

   // Handshake uses the registered ready, so no input reaches any output.
   assign accept = valid_in & ready_out;

   // Next-state: shift/count down in SHIFT, finish on the last bit, reload on accept.
   always_comb begin
      nxt_state      = state;
      nxt_shreg      = shreg;
      nxt_cnt        = cnt;
      nxt_word_count = word_count;
      if (state == S_SHIFT) begin
         nxt_shreg = {shreg[FRAME-2:0], 1'b0};
         nxt_cnt   = cnt - CW'(1);
         if (cnt == CW'(1)) begin
            nxt_word_count = word_count + 8'd1;
            nxt_state      = S_IDLE;
         end
      end
      if (accept) begin
         nxt_shreg = load_word;
         nxt_cnt   = CW'(FRAME);
         nxt_state = S_SHIFT;
      end
   end

   // State and registered outputs, decoded from the next-state values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         shreg       <= '0;
         cnt         <= '0;
         word_count  <= 8'd0;
         ready_out   <= 1'b1;
         serial_out  <= IDLE_BIT;
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= nxt_state;
         shreg       <= nxt_shreg;
         cnt         <= nxt_cnt;
         word_count  <= nxt_word_count;
         ready_out   <= (nxt_state == S_IDLE) || (nxt_cnt == CW'(1));
         serial_out  <= (nxt_state == S_SHIFT) ? nxt_shreg[FRAME-1] : IDLE_BIT;
         bit_valid   <= (nxt_state == S_SHIFT);
         busy        <= (nxt_state == S_SHIFT);
         frame_start <= (nxt_state == S_SHIFT) && (nxt_cnt == CW'(FRAME));
      end
   end

endmodule
